i2c_slave_regfile: RTL and testbench

I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

---
 rtl/i2c_slave_regfile_if.sv | 9 +
 rtl/i2c_slave_regfile.sv | 225 ++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_regfile_if.sv
// I2C pin bundle between the pad ring and the register-file slave.
interface i2c_slave_regfile_if;
  logic scl;
  logic sda_in;
  logic sda_oe;

  modport slave  (input scl, input sda_in, output sda_oe);
  modport master (output scl, output sda_in, input sda_oe);
endinterface

// File: rtl/i2c_slave_regfile.sv
// I2C slave with an auto-incrementing pointer into a 2**PTR_W x 8 register file.
// Optional majority glitch filter on SCL/SDA: define I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h48,
  parameter int         PTR_W      = 5
) (
  input  logic               clk,
  input  logic               reset,
  i2c_slave_regfile_if.slave bus,
  input  logic [PTR_W-1:0]   loc_radd,
  output logic [7:0]         loc_rdata,
  input  logic               loc_w,
  input  logic [PTR_W-1:0]   loc_wadd,
  input  logic [7:0]         loc_din,
  output logic               bus_wr,
  output logic               busy
);

  localparam int DEPTH = 2**PTR_W;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  state_t           state, state_next;
  logic [1:0]       scl_sync, sda_sync;
  logic             scl_line, sda_line, scl_q, sda_q;
  logic             scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]       bit_cnt;
  logic [7:0]       shreg, rd_byte;
  logic [PTR_W-1:0] ptr;
  logic             mack, sda_oe_r, oe_next;
  logic             cnt_clr, cnt_inc, shift_in, rd_load, rd_shift;
  logic             ptr_load, ptr_inc, bus_we, mack_sample, busy_set, busy_clr;
  logic [7:0]       regs [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl};
      sda_sync <= {sda_sync[0], bus.sda_in};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [2:0] scl_hist, sda_hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_hist <= 3'b111;
      sda_hist <= 3'b111;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[1]};
      sda_hist <= {sda_hist[1:0], sda_sync[1]};
    end
  end

  assign scl_line = (scl_hist[0] & scl_hist[1]) | (scl_hist[0] & scl_hist[2]) | (scl_hist[1] & scl_hist[2]);
  assign sda_line = (sda_hist[0] & sda_hist[1]) | (sda_hist[0] & sda_hist[2]) | (sda_hist[1] & sda_hist[2]);
`else
  assign scl_line = scl_sync[1];
  assign sda_line = sda_sync[1];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_line;
      sda_q <= sda_line;
    end
  end

  assign scl_rise  = scl_line & ~scl_q;
  assign scl_fall  = ~scl_line & scl_q;
  assign start_det = scl_line & scl_q & sda_q & ~sda_line;
  assign stop_det  = scl_line & scl_q & ~sda_q & sda_line;
  assign rd_byte   = regs[ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // START/STOP pre-empt everything; otherwise SDA is sampled on SCL rise and driven on SCL fall.
  always_comb begin
    state_next  = state;
    oe_next     = sda_oe_r;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    shift_in    = 1'b0;
    rd_load     = 1'b0;
    rd_shift    = 1'b0;
    ptr_load    = 1'b0;
    ptr_inc     = 1'b0;
    bus_we      = 1'b0;
    mack_sample = 1'b0;
    busy_set    = 1'b0;
    busy_clr    = 1'b0;
    if (stop_det) begin
      state_next = IDLE;
      oe_next    = 1'b0;
      busy_clr   = 1'b1;
    end else if (start_det) begin
      state_next = ADDR;
      oe_next    = 1'b0;
      cnt_clr    = 1'b1;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shift_in = 1'b1;
            cnt_inc  = 1'b1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (state == ADDR) begin
              if (shreg[7:1] == SLAVE_ADDR) begin
                state_next = ADDR_ACK;
                oe_next    = 1'b1;
                busy_set   = 1'b1;
              end else begin
                state_next = IDLE;
              end
            end else if (state == PTR) begin
              ptr_load   = 1'b1;
              state_next = PTR_ACK;
              oe_next    = 1'b1;
            end else begin
              bus_we     = 1'b1;
              ptr_inc    = 1'b1;
              state_next = WDATA_ACK;
              oe_next    = 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_clr = 1'b1;
            if (shreg[0]) begin
              state_next = RDATA;
              rd_load    = 1'b1;
              oe_next    = ~rd_byte[7];
            end else begin
              state_next = PTR;
              oe_next    = 1'b0;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            state_next = WDATA;
            oe_next    = 1'b0;
            cnt_clr    = 1'b1;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_inc = 1'b1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_next = RACK;
              oe_next    = 1'b0;
              ptr_inc    = 1'b1;
            end else begin
              rd_shift = 1'b1;
              oe_next  = ~shreg[6];
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            mack_sample = 1'b1;
          end else if (scl_fall) begin
            if (!mack) begin
              state_next = RDATA;
              rd_load    = 1'b1;
              oe_next    = ~rd_byte[7];
              cnt_clr    = 1'b1;
            end else begin
              state_next = IDLE;
              oe_next    = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Local write is issued first so a same-address bus write overrides it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      ptr       <= '0;
      mack      <= 1'b1;
      sda_oe_r  <= 1'b0;
      busy      <= 1'b0;
      bus_wr    <= 1'b0;
      loc_rdata <= 8'h00;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else begin
      sda_oe_r <= oe_next;
      bus_wr   <= bus_we;
      if (busy_set)      busy <= 1'b1;
      else if (busy_clr) busy <= 1'b0;
      if (cnt_clr)      bit_cnt <= 4'd0;
      else if (cnt_inc) bit_cnt <= bit_cnt + 4'd1;
      if (shift_in)      shreg <= {shreg[6:0], sda_line};
      else if (rd_load)  shreg <= rd_byte;
      else if (rd_shift) shreg <= {shreg[6:0], 1'b0};
      if (ptr_load)     ptr <= shreg[PTR_W-1:0];
      else if (ptr_inc) ptr <= ptr + PTR_W'(1);
      if (mack_sample) mack <= sda_line;
      if (loc_w)  regs[loc_wadd] <= loc_din;
      if (bus_we) regs[ptr] <= shreg;
      loc_rdata <= regs[loc_radd];
    end
  end

  assign bus.sda_oe = sda_oe_r;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banged I2C master drives an open-drain SDA model.
module tb_i2c_slave_regfile;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       m_scl, m_sda_low;
  logic [4:0] loc_radd, loc_wadd;
  logic [7:0] loc_rdata, loc_din;
  logic       loc_w, bus_wr, busy;
  int         checks = 0;
  int         errors = 0;
  int         wr_pulses = 0;

  i2c_slave_regfile_if bus();

  assign bus.scl    = m_scl;
  assign bus.sda_in = ~(m_sda_low | bus.sda_oe);

  i2c_slave_regfile #(.SLAVE_ADDR(7'h48), .PTR_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .loc_radd  (loc_radd),
    .loc_rdata (loc_rdata),
    .loc_w     (loc_w),
    .loc_wadd  (loc_wadd),
    .loc_din   (loc_din),
    .bus_wr    (bus_wr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus_wr === 1'b1) wr_pulses++;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    m_sda_low = 1'b0; wait_clk(Q);
    m_scl = 1'b1;     wait_clk(Q);
    m_sda_low = 1'b1; wait_clk(Q);
    m_scl = 1'b0;     wait_clk(Q);
  endtask

  task automatic i2c_stop;
    m_sda_low = 1'b1; wait_clk(Q);
    m_scl = 1'b1;     wait_clk(Q);
    m_sda_low = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_bit(input logic drive_low, output logic line);
    m_sda_low = drive_low; wait_clk(Q);
    m_scl = 1'b1;          wait_clk(Q/2);
    line = bus.sda_in;     wait_clk(Q/2);
    m_scl = 1'b0;          wait_clk(Q);
  endtask

  task automatic i2c_write_byte(input logic [7:0] b, output logic acked);
    logic line;
    for (int i = 7; i >= 0; i--) i2c_bit(~b[i], line);
    i2c_bit(1'b0, line);
    acked = ~line;
  endtask

  task automatic i2c_read_byte(input logic ack, output logic [7:0] b);
    logic line;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b0, line);
      b[i] = line;
    end
    i2c_bit(ack, line);
  endtask

  task automatic read_loc(input logic [4:0] a, output logic [7:0] d);
    loc_radd = a;
    @(negedge clk);
    d = loc_rdata;
  endtask

  task automatic write_loc(input logic [4:0] a, input logic [7:0] d);
    loc_wadd = a; loc_din = d; loc_w = 1'b1;
    @(negedge clk);
    loc_w = 1'b0;
  endtask

  task automatic wait_bus_wr(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (bus_wr === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; m_scl = 1'b1; m_sda_low = 1'b0;
    loc_w = 1'b0; loc_wadd = '0; loc_din = '0; loc_radd = '0;
    wait_clk(4);
    checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_sda_oe: got %b expected 0", bus.sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (bus_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_wr: got %b expected 0", bus_wr); end
    checks++; if (loc_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_loc_rdata: got %h expected 00", loc_rdata); end
    reset = 1'b1;
    wait_clk(4);
    checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_sda_oe: got %b expected 0", bus.sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_write;
    logic a0, a1, a2;
    logic [7:0] d;
    int p0;
    p0 = wr_pulses;
    i2c_start;
    i2c_write_byte(8'h90, a0);
    checks++; if (a0 !== 1'b1) begin errors++; $display("[TB] FAIL write_addr_ack: got %b expected 1", a0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL write_busy: got %b expected 1", busy); end
    i2c_write_byte(8'h03, a1);
    i2c_write_byte(8'hA5, a2);
    checks++; if ({a1, a2} !== 2'b11) begin errors++; $display("[TB] FAIL write_ptr_data_ack: got %b expected 11", {a1, a2}); end
    checks++; if (wr_pulses - p0 !== 1) begin errors++; $display("[TB] FAIL write_bus_wr_pulses: got %0d expected 1", wr_pulses - p0); end
    i2c_stop;
    wait_clk(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL write_busy_after_stop: got %b expected 0", busy); end
    read_loc(5'd3, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("[TB] FAIL write_reg3: got %h expected a5", d); end
  endtask

  task automatic test_wrap;
    logic a0, a1, a2, a3;
    logic [7:0] d;
    i2c_start;
    i2c_write_byte(8'h90, a0);
    i2c_write_byte(8'h1F, a1);
    i2c_write_byte(8'h11, a2);
    i2c_write_byte(8'h22, a3);
    i2c_stop;
    checks++; if ({a0, a1, a2, a3} !== 4'hF) begin errors++; $display("[TB] FAIL wrap_acks: got %b expected 1111", {a0, a1, a2, a3}); end
    read_loc(5'd31, d);
    checks++; if (d !== 8'h11) begin errors++; $display("[TB] FAIL wrap_reg31: got %h expected 11", d); end
    read_loc(5'd0, d);
    checks++; if (d !== 8'h22) begin errors++; $display("[TB] FAIL wrap_reg0: got %h expected 22", d); end
  endtask

  task automatic test_read;
    logic a0, a1, a2;
    logic [7:0] b0, b1;
    write_loc(5'd5, 8'h5A);
    write_loc(5'd6, 8'hC3);
    i2c_start;
    i2c_write_byte(8'h90, a0);
    i2c_write_byte(8'h05, a1);
    i2c_start;
    i2c_write_byte(8'h91, a2);
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("[TB] FAIL read_acks: got %b expected 111", {a0, a1, a2}); end
    i2c_read_byte(1'b1, b0);
    i2c_read_byte(1'b0, b1);
    checks++; if (b0 !== 8'h5A) begin errors++; $display("[TB] FAIL read_byte0: got %h expected 5a", b0); end
    checks++; if (b1 !== 8'hC3) begin errors++; $display("[TB] FAIL read_byte1: got %h expected c3", b1); end
    checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL read_released_after_nack: got %b expected 0", bus.sda_oe); end
    i2c_stop;
    wait_clk(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL read_busy_after_stop: got %b expected 0", busy); end
  endtask

  task automatic test_bad_addr;
    logic a0, a1, a2;
    logic [7:0] d;
    int p0;
    p0 = wr_pulses;
    i2c_start;
    i2c_write_byte(8'h92, a0);
    checks++; if (a0 !== 1'b0) begin errors++; $display("[TB] FAIL bad_addr_ack: got %b expected 0", a0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bad_addr_busy: got %b expected 0", busy); end
    i2c_write_byte(8'h02, a1);
    i2c_write_byte(8'hFF, a2);
    checks++; if ({a1, a2} !== 2'b00) begin errors++; $display("[TB] FAIL bad_addr_later_acks: got %b expected 00", {a1, a2}); end
    i2c_stop;
    checks++; if (wr_pulses !== p0) begin errors++; $display("[TB] FAIL bad_addr_bus_wr: got %0d expected %0d", wr_pulses, p0); end
    read_loc(5'd2, d);
    checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL bad_addr_reg2: got %h expected 00", d); end
  endtask

  task automatic test_back_to_back;
    logic a0, a1, a2, a3, ok1, ok2;
    logic [7:0] d;
    i2c_start;
    i2c_write_byte(8'h90, a0);
    i2c_write_byte(8'h02, a1);
    fork
      begin
        i2c_write_byte(8'h77, a2);
        i2c_write_byte(8'h33, a3);
      end
      begin
        loc_wadd = 5'd2; loc_din = 8'h88; loc_w = 1'b1;
        wait_bus_wr(ok1);
        loc_wadd = 5'd4; loc_din = 8'h44;
        @(negedge clk);
        wait_bus_wr(ok2);
        loc_w = 1'b0;
      end
    join
    i2c_stop;
    checks++; if ({a0, a1, a2, a3, ok1, ok2} !== 6'h3F) begin errors++; $display("[TB] FAIL b2b_acks_and_pulses: got %b expected 111111", {a0, a1, a2, a3, ok1, ok2}); end
    read_loc(5'd2, d);
    checks++; if (d !== 8'h77) begin errors++; $display("[TB] FAIL b2b_same_addr_reg2: got %h expected 77", d); end
    read_loc(5'd3, d);
    checks++; if (d !== 8'h33) begin errors++; $display("[TB] FAIL b2b_bus_reg3: got %h expected 33", d); end
    read_loc(5'd4, d);
    checks++; if (d !== 8'h44) begin errors++; $display("[TB] FAIL b2b_loc_reg4: got %h expected 44", d); end
  endtask

  task automatic test_reset_mid;
    logic a0, a1, a2;
    logic [7:0] d;
    i2c_start;
    i2c_write_byte(8'h90, a0);
    i2c_write_byte(8'h05, a1);
    i2c_start;
    i2c_write_byte(8'h91, a2);
    checks++; if (bus.sda_oe !== 1'b1) begin errors++; $display("[TB] FAIL mid_driving_zero: got %b expected 1", bus.sda_oe); end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_release: got %b expected 0", bus.sda_oe); end
    @(negedge clk);
    m_scl = 1'b1; m_sda_low = 1'b0;
    wait_clk(4);
    reset = 1'b1;
    wait_clk(4);
    read_loc(5'd5, d);
    checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL mid_regs_cleared: got %h expected 00", d); end
    i2c_start;
    i2c_write_byte(8'h90, a0);
    i2c_write_byte(8'h0A, a1);
    i2c_write_byte(8'h5C, a2);
    i2c_stop;
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("[TB] FAIL mid_fresh_acks: got %b expected 111", {a0, a1, a2}); end
    read_loc(5'd10, d);
    checks++; if (d !== 8'h5C) begin errors++; $display("[TB] FAIL mid_fresh_reg10: got %h expected 5c", d); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_wrap;
    test_read;
    test_bad_addr;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
